ball_controller: RTL and testbench

Frame-rate sequencer for the ball in the pong playfield. It detects the start of each frame from vertical sync and runs a serve/play/game-over state machine. Each frame it steps the ball position and resolves bounces against the border and the paddle, and it counts misses. Its `ball_x`/`ball_y` outputs feed the pixel-level ball distance test in the top level, replacing the static ball registers.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/vsync_tick.sv | 28 ++
 rtl/ball_controller.sv | 215 +++++++++++++++++++++
 tb/tb_ball_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong playfield blocks.
//   - ball_state_t : ball sequencer FSM encoding (SERVE..OVER)
//   - PONG_*       : default playfield geometry and position bus width
package pong_pkg;

  localparam int PONG_POSITION_REG_MAX = 11;
  localparam int PONG_GRAPHICS_WIDTH   = 1280;
  localparam int PONG_GRAPHICS_HEIGHT  = 800;
  localparam int PONG_BORDER_WIDTH     = 50;
  localparam int PONG_BALL_RADIUS      = 10;
  localparam int PONG_BALL_SPEED       = 6;
  localparam int PONG_PADDLE_X         = 110;
  localparam int PONG_PADDLE_WIDTH     = 20;
  localparam int PONG_PADDLE_LENGTH    = 200;

  typedef enum logic [2:0] {
    ST_SERVE  = 3'd0,
    ST_PLAY   = 3'd1,
    ST_STEP_X = 3'd2,
    ST_STEP_Y = 3'd3,
    ST_OVER   = 3'd4
  } ball_state_t;

endpackage

// File: rtl/vsync_tick.sv
// vsync_tick: rising-edge detector on vertical sync, giving one tick per frame.
// Ports:
//   pixel_clock       in  : clock
//   reset             in  : synchronous, active-high
//   vga_vertical_sync in  : vsync, already in the pixel_clock domain
//   tick              out : high for the cycle in which vsync is seen rising
module vsync_tick (
  input  logic pixel_clock,
  input  logic reset,
  input  logic vga_vertical_sync,
  output logic tick
);

  logic vsync_last_reg;

  // The last-vsync register resets high so a vsync already high when reset
  // is released does not produce a spurious tick.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      vsync_last_reg <= 1'b1;
    end else begin
      vsync_last_reg <= vga_vertical_sync;
    end
  end

  assign tick = vga_vertical_sync & ~vsync_last_reg;

endmodule

// File: rtl/ball_controller.sv
// ball_controller: frame-rate ball sequencer for the pong playfield.
// Once per frame it steps the ball, bounces it off the border and paddle,
// and counts misses through a SERVE/PLAY/STEP_X/STEP_Y/OVER state machine.
// Ports:
//   pixel_clock       in  : clock
//   reset             in  : synchronous, active-high
//   vga_vertical_sync in  : vsync (pixel_clock domain)
//   paddle_y          in  : paddle top edge
//   serve_button      in  : restarts play from game over (level)
//   ball_x, ball_y    out : ball centre
//   miss_pulse        out : one-cycle strobe per miss
//   miss_count        out : misses this game
//   game_over         out : high while in OVER
//   state             out : FSM state
module ball_controller
  import pong_pkg::*;
#(
  parameter int GRAPHICS_WIDTH     = PONG_GRAPHICS_WIDTH,
  parameter int GRAPHICS_HEIGHT    = PONG_GRAPHICS_HEIGHT,
  parameter int POSITION_REG_MAX   = PONG_POSITION_REG_MAX,
  parameter int BORDER_WIDTH       = PONG_BORDER_WIDTH,
  parameter int BALL_RADIUS        = PONG_BALL_RADIUS,
  parameter int BALL_SPEED         = PONG_BALL_SPEED,
  parameter int PADDLE_X           = PONG_PADDLE_X,
  parameter int PADDLE_WIDTH       = PONG_PADDLE_WIDTH,
  parameter int PADDLE_LENGTH      = PONG_PADDLE_LENGTH,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int MISS_LIMIT         = 3
) (
  input  logic                    pixel_clock,
  input  logic                    reset,
  input  logic                    vga_vertical_sync,
  input  logic [POSITION_REG_MAX:0] paddle_y,
  input  logic                    serve_button,
  output logic [POSITION_REG_MAX:0] ball_x,
  output logic [POSITION_REG_MAX:0] ball_y,
  output logic                    miss_pulse,
  output logic [1:0]              miss_count,
  output logic                    game_over,
  output logic [2:0]              state
);

  typedef logic [POSITION_REG_MAX:0] pos_t;

  localparam int SERVE_CNT_W = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [SERVE_CNT_W-1:0] SERVE_RELOAD = SERVE_CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [SERVE_CNT_W-1:0] SERVE_ONE    = SERVE_CNT_W'(1);

  localparam pos_t CENTER_X     = pos_t'(GRAPHICS_WIDTH / 2);
  localparam pos_t CENTER_Y     = pos_t'(GRAPHICS_HEIGHT / 2);
  localparam pos_t SPEED        = pos_t'(BALL_SPEED);
  localparam pos_t RADIUS       = pos_t'(BALL_RADIUS);
  // All limits are pre-folded so the datapath only adds to the ball position.
  localparam pos_t X_RIGHT_WALL = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH);
  localparam pos_t X_RIGHT_REST = pos_t'(GRAPHICS_WIDTH - BORDER_WIDTH - BALL_RADIUS);
  localparam pos_t X_MISS       = pos_t'(BORDER_WIDTH + BALL_RADIUS + BALL_SPEED);
  localparam pos_t PADDLE_FACE  = pos_t'(PADDLE_X + PADDLE_WIDTH + BALL_RADIUS);
  localparam pos_t PADDLE_CATCH = pos_t'(PADDLE_X + PADDLE_WIDTH + BALL_RADIUS + BALL_SPEED);
  localparam pos_t PADDLE_SPAN  = pos_t'(PADDLE_LENGTH + BALL_RADIUS);
  localparam pos_t Y_TOP_HIT    = pos_t'(BORDER_WIDTH + BALL_RADIUS + BALL_SPEED);
  localparam pos_t Y_TOP_REST   = pos_t'(BORDER_WIDTH + BALL_RADIUS);
  localparam pos_t Y_BOT_WALL   = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH);
  localparam pos_t Y_BOT_REST   = pos_t'(GRAPHICS_HEIGHT - BORDER_WIDTH - BALL_RADIUS);

  logic tick;

  vsync_tick u_vsync_tick (
    .pixel_clock       (pixel_clock),
    .reset             (reset),
    .vga_vertical_sync (vga_vertical_sync),
    .tick              (tick)
  );

  ball_state_t             state_reg, state_next;
  pos_t                    ball_x_reg, ball_x_next;
  pos_t                    ball_y_reg, ball_y_next;
  logic                    dx_neg_reg, dx_neg_next;
  logic                    dy_neg_reg, dy_neg_next;
  logic [1:0]              miss_count_reg, miss_count_next;
  logic                    miss_pulse_reg, miss_pulse_next;
  logic                    game_over_reg;
  logic [SERVE_CNT_W-1:0]  serve_cnt_reg, serve_cnt_next;

  logic       paddle_hit;
  logic       left_miss;
  logic [1:0] miss_count_inc;
  logic       miss_final;

  // Paddle hit: ball crosses the paddle face this step and overlaps it
  // vertically. It is tested first so a hit always wins over a miss.
  assign paddle_hit = dx_neg_reg
                    && (ball_x_reg > PADDLE_FACE)
                    && (ball_x_reg <= PADDLE_CATCH)
                    && (ball_y_reg + RADIUS >= paddle_y)
                    && (ball_y_reg <= paddle_y + PADDLE_SPAN);
  assign left_miss      = dx_neg_reg && !paddle_hit && (ball_x_reg <= X_MISS);
  assign miss_count_inc = miss_count_reg + 2'd1;
  assign miss_final     = (miss_count_inc == 2'(MISS_LIMIT));

  // State and datapath registers
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_reg      <= ST_SERVE;
      ball_x_reg     <= CENTER_X;
      ball_y_reg     <= CENTER_Y;
      dx_neg_reg     <= 1'b0;
      dy_neg_reg     <= 1'b0;
      miss_count_reg <= 2'd0;
      miss_pulse_reg <= 1'b0;
      game_over_reg  <= 1'b0;
      serve_cnt_reg  <= SERVE_RELOAD;
    end else begin
      state_reg      <= state_next;
      ball_x_reg     <= ball_x_next;
      ball_y_reg     <= ball_y_next;
      dx_neg_reg     <= dx_neg_next;
      dy_neg_reg     <= dy_neg_next;
      miss_count_reg <= miss_count_next;
      miss_pulse_reg <= miss_pulse_next;
      game_over_reg  <= (state_next == ST_OVER);
      serve_cnt_reg  <= serve_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SERVE:  if (tick && (serve_cnt_reg <= SERVE_ONE)) state_next = ST_PLAY;
      ST_PLAY:   if (tick) state_next = ST_STEP_X;
      ST_STEP_X: begin
        if (left_miss) state_next = miss_final ? ST_OVER : ST_SERVE;
        else           state_next = ST_STEP_Y;
      end
      ST_STEP_Y: state_next = ST_PLAY;
      ST_OVER:   if (tick && serve_button) state_next = ST_SERVE;
      default:   state_next = ST_SERVE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    ball_x_next     = ball_x_reg;
    ball_y_next     = ball_y_reg;
    dx_neg_next     = dx_neg_reg;
    dy_neg_next     = dy_neg_reg;
    miss_count_next = miss_count_reg;
    miss_pulse_next = 1'b0;
    serve_cnt_next  = serve_cnt_reg;
    case (state_reg)
      ST_SERVE: begin
        ball_x_next = CENTER_X;
        ball_y_next = CENTER_Y;
        if (tick) begin
          if (serve_cnt_reg <= SERVE_ONE) begin
            // Launch rightwards; alternate the vertical direction each serve.
            serve_cnt_next = SERVE_RELOAD;
            dx_neg_next    = 1'b0;
            dy_neg_next    = ~dy_neg_reg;
          end else begin
            serve_cnt_next = serve_cnt_reg - SERVE_ONE;
          end
        end
      end
      ST_STEP_X: begin
        if (paddle_hit) begin
          ball_x_next = PADDLE_FACE;
          dx_neg_next = 1'b0;
        end else if (left_miss) begin
          miss_pulse_next = 1'b1;
          miss_count_next = miss_count_inc;
          ball_x_next     = CENTER_X;
          ball_y_next     = CENTER_Y;
          serve_cnt_next  = SERVE_RELOAD;
        end else if (dx_neg_reg) begin
          ball_x_next = ball_x_reg - SPEED;
        end else if (ball_x_reg + SPEED + RADIUS >= X_RIGHT_WALL) begin
          ball_x_next = X_RIGHT_REST;
          dx_neg_next = 1'b1;
        end else begin
          ball_x_next = ball_x_reg + SPEED;
        end
      end
      ST_STEP_Y: begin
        if (dy_neg_reg) begin
          if (ball_y_reg <= Y_TOP_HIT) begin
            ball_y_next = Y_TOP_REST;
            dy_neg_next = 1'b0;
          end else begin
            ball_y_next = ball_y_reg - SPEED;
          end
        end else if (ball_y_reg + SPEED + RADIUS >= Y_BOT_WALL) begin
          ball_y_next = Y_BOT_REST;
          dy_neg_next = 1'b1;
        end else begin
          ball_y_next = ball_y_reg + SPEED;
        end
      end
      ST_OVER: begin
        ball_x_next = CENTER_X;
        ball_y_next = CENTER_Y;
        if (tick && serve_button) miss_count_next = 2'd0;
      end
      default: ;
    endcase
  end

  assign ball_x     = ball_x_reg;
  assign ball_y     = ball_y_reg;
  assign miss_pulse = miss_pulse_reg;
  assign miss_count = miss_count_reg;
  assign game_over  = game_over_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_ball_controller.sv
// tb_ball_controller: directed self-checking bench for ball_controller.
// Drives vsync frames, follows the ball trajectory from serve through
// border bounces, a paddle hit, three misses, game over and restart.
module tb_ball_controller;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        vga_vertical_sync = 1'b0;
  logic        serve_button = 1'b0;
  logic [11:0] paddle_y = 12'd400;
  logic [11:0] ball_x, ball_y;
  logic        miss_pulse, game_over;
  logic [1:0]  miss_count;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  // Snapshot after each of the three edges following a vsync rise
  logic [2:0]  tr_state [3];
  logic [11:0] tr_x     [3];
  logic [11:0] tr_y     [3];
  logic        tr_pulse [3];

  ball_controller dut (
    .pixel_clock       (pixel_clock),
    .reset             (reset),
    .vga_vertical_sync (vga_vertical_sync),
    .paddle_y          (paddle_y),
    .serve_button      (serve_button),
    .ball_x            (ball_x),
    .ball_y            (ball_y),
    .miss_pulse        (miss_pulse),
    .miss_count        (miss_count),
    .game_over         (game_over),
    .state             (state)
  );

  always #5 pixel_clock = ~pixel_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge pixel_clock);
    vga_vertical_sync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pixel_clock);
      tr_state[i] = state;
      tr_x[i]     = ball_x;
      tr_y[i]     = ball_y;
      tr_pulse[i] = miss_pulse;
    end
    vga_vertical_sync = 1'b0;
    repeat (3) @(negedge pixel_clock);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge pixel_clock);
    chk("rst_x", 32'(ball_x), 640);
    chk("rst_y", 32'(ball_y), 400);
    chk("rst_state", 32'(state), 0);
    chk("rst_pulse", 32'(miss_pulse), 0);
    chk("rst_count", 32'(miss_count), 0);
    chk("rst_over", 32'(game_over), 0);
    reset = 1'b0;
    $display("[TB] reset checked");

    // Rally 1: paddle low enough to catch the ball on its first return
    paddle_y = 12'd50;
    for (int i = 1; i <= 60; i++) begin
      frame();
      chk("serve_x", 32'(ball_x), 640);
      chk("serve_y", 32'(ball_y), 400);
      chk("serve_state", 32'(state), (i == 60) ? 32'd1 : 32'd0);
    end
    $display("[TB] serve delay: state=%0d", state);

    // First play tick: latency of x then y
    frame();
    chk("k1_state_n", 32'(tr_state[0]), 2);
    chk("k1_x_n", 32'(tr_x[0]), 640);
    chk("k1_x_n1", 32'(tr_x[1]), 646);
    chk("k1_state_n1", 32'(tr_state[1]), 3);
    chk("k1_y_n1", 32'(tr_y[1]), 400);
    chk("k1_y_n2", 32'(tr_y[2]), 394);
    chk("k1_state_n2", 32'(tr_state[2]), 1);
    $display("[TB] first step: x=%0d y=%0d", tr_x[2], tr_y[2]);

    frames(94);                                   // k = 2..95
    frame();                                      // k = 96
    chk("k96_x", 32'(ball_x), 1216);
    frame();                                      // k = 97: right wall clamp
    chk("right_clamp_x", 32'(ball_x), 1220);
    chk("right_clamp_y", 32'(ball_y), 300);
    chk("right_clamp_pulse", 32'(tr_pulse[1]), 0);
    frame();                                      // k = 98: now moving left
    chk("k98_x", 32'(ball_x), 1214);
    $display("[TB] right wall: x=%0d", ball_x);

    frames(178);                                  // k = 99..276
    chk("k276_x", 32'(ball_x), 146);
    frame();                                      // k = 277: paddle hit
    chk("hit_x", 32'(ball_x), 140);
    chk("hit_y", 32'(ball_y), 104);
    chk("hit_pulse", 32'(tr_pulse[1]), 0);
    chk("hit_count", 32'(miss_count), 0);
    frame();                                      // k = 278: rebounds right
    chk("hit_rebound_x", 32'(ball_x), 146);
    $display("[TB] paddle hit: x=%0d", ball_x);

    @(negedge pixel_clock); reset = 1'b1;
    @(negedge pixel_clock); reset = 1'b0;

    // Three rallies with the paddle out of reach: each ends in a miss
    paddle_y = 12'd400;
    for (int g = 1; g <= 3; g++) begin
      frames(60);
      chk("miss_serve_state", 32'(state), 1);
      frames(276);
      chk("miss_k276_x", 32'(ball_x), 146);
      frame();
      chk("miss_k277_x", 32'(ball_x), 140);
      frame();
      chk("miss_k278_x", 32'(ball_x), 134);
      frames(12);
      chk("miss_k290_x", 32'(ball_x), 62);
      chk("miss_k290_count", 32'(miss_count), 32'(g - 1));
      frame();                                    // k = 291: left border
      chk("miss_pulse_n", 32'(tr_pulse[0]), 0);
      chk("miss_pulse_n1", 32'(tr_pulse[1]), 1);
      chk("miss_pulse_n2", 32'(tr_pulse[2]), 0);
      chk("miss_state", 32'(tr_state[1]), (g == 3) ? 32'd4 : 32'd0);
      chk("miss_x", 32'(tr_x[1]), 640);
      chk("miss_y", 32'(tr_y[1]), 400);
      chk("miss_count", 32'(miss_count), 32'(g));
      chk("miss_over", 32'(game_over), (g == 3) ? 32'd1 : 32'd0);
      $display("[TB] miss %0d: count=%0d state=%0d over=%0d", g, miss_count, state, game_over);
    end

    // OVER: tick without button is ignored, with button restarts
    serve_button = 1'b0;
    frame();
    chk("over_hold_state", 32'(state), 4);
    chk("over_hold_count", 32'(miss_count), 3);
    chk("over_hold_over", 32'(game_over), 1);
    chk("over_hold_x", 32'(ball_x), 640);
    serve_button = 1'b1;
    frame();
    serve_button = 1'b0;
    chk("restart_state", 32'(state), 0);
    chk("restart_count", 32'(miss_count), 0);
    chk("restart_over", 32'(game_over), 0);
    $display("[TB] restart: state=%0d count=%0d", state, miss_count);

    // Reset asserted while in STEP_X
    frames(60);
    chk("pre_stepx_state", 32'(state), 1);
    @(negedge pixel_clock);
    vga_vertical_sync = 1'b1;
    @(negedge pixel_clock);
    chk("stepx_state", 32'(state), 2);
    reset = 1'b1;
    @(negedge pixel_clock);
    chk("midrst_x", 32'(ball_x), 640);
    chk("midrst_y", 32'(ball_y), 400);
    chk("midrst_state", 32'(state), 0);
    chk("midrst_pulse", 32'(miss_pulse), 0);
    chk("midrst_count", 32'(miss_count), 0);
    chk("midrst_over", 32'(game_over), 0);
    vga_vertical_sync = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge pixel_clock);
    $display("[TB] mid-step reset: x=%0d state=%0d", ball_x, state);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
